seg_scan: RTL

Time-multiplexed seven-segment display driver sitting directly downstream of the cascaded BCD digit counters (seg0, seg1, …). It takes DIGITS packed BCD digits, snapshots them once per scan frame, and drives one shared segment bus plus one-hot digit selects. It also provides a ghost-suppression blank gap between digits, optional leading-zero blanking, per-digit decimal points and a frame-done pulse.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_bcd2seg.sv | 27 ++
 rtl/seg_scan.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared segment encodings for the multiplexed seven-segment driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_bcd2seg.sv
// BCD digit to active-high segment pattern.
// Codes above 9 are not valid BCD and show nothing.
module seg_bcd2seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner with per-frame snapshot,
// blank gap, leading-zero blanking and decimal points.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   dig_bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PC_BLK   = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] SEL_OFF =
    SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       r_pc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_dp;
  logic                r_lz;
  logic [6:0]          r_seg;
  logic                r_dpo;
  logic [DIGITS-1:0]   r_sel;
  logic                r_fd;

  logic                w_slot_end;
  logic                w_frame_end;
  logic                w_blank;
  logic [3:0]          w_cur;
  logic [6:0]          w_dec;
  logic [6:0]          w_seg_hi;
  logic [DIGITS-1:0]   w_lzm;
  logic [DIGITS-1:0]   w_hot;
  logic                w_allz;

  assign w_slot_end  = (r_pc == PC_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_blank     = (r_pc < PC_BLK);
  assign w_cur       = r_bcd[{r_idx, 2'b00} +: 4];
  assign w_hot       = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;

  seg_bcd2seg u_dec (
    .i_bcd (w_cur),
    .o_seg (w_dec)
  );

  // Walk down from the top digit; a digit is a leading zero while
  // everything above it (and itself) is zero and it has no dp.
  always_comb begin
    w_allz = 1'b1;
    w_lzm  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_allz   = w_allz & (r_bcd[4*i +: 4] == 4'd0);
      w_lzm[i] = r_lz & (i != 0) & ~r_dp[i] & w_allz;
    end
  end

  assign w_seg_hi = w_lzm[r_idx] ? SEG_BLANK : w_dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc  <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_pc  <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pc  <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd <= '0;
      r_dp  <= '0;
      r_lz  <= 1'b0;
    end else if (w_frame_end) begin
      r_bcd <= dig_bcd;
      r_dp  <= dp_in;
      r_lz  <= lz_blank_en;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_OFF;
      r_dpo <= DP_OFF;
      r_sel <= SEL_OFF;
      r_fd  <= 1'b0;
    end else begin
      r_fd <= w_frame_end;
      if (w_blank) begin
        r_seg <= SEG_OFF;
        r_dpo <= DP_OFF;
        r_sel <= SEL_OFF;
      end else begin
        r_seg <= w_seg_hi ^ SEG_OFF;
        r_dpo <= r_dp[r_idx] ^ DP_OFF;
        r_sel <= w_hot ^ SEL_OFF;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dpo;
  assign sel        = r_sel;
  assign frame_done = r_fd;

endmodule
